dmem_bytelane: RTL and testbench

// - Parametrised data memory for the pipeline's MEM stage. Successor to the plain word-wide dmem.
// - Adds RISC-V byte/half/word access sizes selected by funct3, sign/zero-extended loads and alignment checking.
// - Adds a configurable registered read latency and a req/ready/rsp_valid handshake.
// - Adds an optional post-reset hardware clear of the whole array.

---
 rtl/dmem_bytelane.sv | 160 ++++++++++++++++
 tb/tb_dmem_bytelane.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with B/H/W loads and stores, alignment checks and optional post-reset clear.
// Response READ_LAT cycles after acceptance; ready=0 only while clearing, responses are never back-pressured.
module dmem_bytelane #(
   parameter int DEPTH          = 256,
   parameter int READ_LAT       = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic        ready,
   output logic        rsp_valid,
   output logic [31:0] rd,
   output logic        err
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_IDLE  = 2'd2;
   localparam logic [1:0] ST_RST   = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_INIT;

   logic [1:0]          state_q, state_d;
   logic [AW-1:0]       clr_idx_q, clr_idx_d;
   logic                clr_we;
   logic [31:0]         mem_q [DEPTH];

   logic                acc, legal, misal, bad, st_we;
   logic [AW-1:0]       widx;
   logic [1:0]          lane;
   logic [31:0]         word, shifted, rd_new, wdat;
   logic [7:0]          byte_v;
   logic [15:0]         half_v;
   logic [3:0]          be;

   logic [READ_LAT-1:0] vld_q, vld_d, err_q, err_d;
   logic [31:0]         dat_q [READ_LAT];
   logic [31:0]         dat_d [READ_LAT];

   logic                unused_a;
   assign unused_a = ^a[31:AW+2];

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      clr_we    = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_CLEAR: begin
            clr_we    = 1'b1;
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
         end
         ST_IDLE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RST;
         clr_idx_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign acc   = req && ready;
   assign widx  = a[AW+1:2];
   assign lane  = a[1:0];

   always_comb begin
      legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
              (!we && ((funct3 == 3'b100) || (funct3 == 3'b101)));
      misal = ((funct3[1:0] == 2'b01) && a[0]) || ((funct3 == 3'b010) && (lane != 2'b00));
      bad   = !legal || misal;
   end

   // Array read is combinational so a load right after a store sees the stored data.
   always_comb begin
      word    = mem_q[widx];
      shifted = word >> {lane, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = a[1] ? word[31:16] : word[15:0];
      rd_new  = '0;
      if (!we && !bad) begin
         case (funct3)
            3'b000:  rd_new = {{24{byte_v[7]}}, byte_v};
            3'b100:  rd_new = {24'b0, byte_v};
            3'b001:  rd_new = {{16{half_v[15]}}, half_v};
            3'b101:  rd_new = {16'b0, half_v};
            3'b010:  rd_new = word;
            default: rd_new = '0;
         endcase
      end
   end

   always_comb begin
      st_we = acc && we && !bad;
      case (funct3[1:0])
         2'b00: begin
            be   = 4'b0001 << lane;
            wdat = {4{wd[7:0]}};
         end
         2'b01: begin
            be   = a[1] ? 4'b1100 : 4'b0011;
            wdat = {2{wd[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wdat = wd;
         end
      endcase
   end

   // Array contents deliberately survive rst_n; only the clear sequence zeroes them.
   always_ff @(posedge clk) begin
      if (clr_we) begin
         mem_q[clr_idx_q] <= '0;
      end else if (st_we) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem_q[widx][8*i +: 8] <= wdat[8*i +: 8];
      end
   end

   always_comb begin
      vld_d    = vld_q;
      err_d    = err_q;
      vld_d[0] = acc;
      err_d[0] = acc && bad;
      dat_d[0] = acc ? rd_new : 32'b0;
      for (int i = 1; i < READ_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         err_d[i] = err_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         err_q <= '0;
         for (int i = 0; i < READ_LAT; i++) dat_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         err_q <= err_d;
         for (int i = 0; i < READ_LAT; i++) dat_q[i] <= dat_d[i];
      end
   end

   assign rsp_valid = vld_q[READ_LAT-1];
   assign rd        = dat_q[READ_LAT-1];
   assign err       = err_q[READ_LAT-1];
endmodule

// File: tb/tb_dmem_bytelane.sv
// Drives two DUTs (READ_LAT 1 and 3) with identical requests and checks both against a byte-array model.
module tb_dmem_bytelane;
   localparam int DEPTH = 16;
   localparam int LA    = 1;
   localparam int LB    = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0;
   logic [2:0]  funct3 = 3'b0;
   logic [31:0] a = '0, wd = '0;
   logic        rdy_a, vld_a, err_a, rdy_b, vld_b, err_b;
   logic [31:0] rd_a, rd_b;

   dmem_bytelane #(.DEPTH(DEPTH), .READ_LAT(LA), .CLEAR_ON_RESET(1)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .a(a), .wd(wd),
      .ready(rdy_a), .rsp_valid(vld_a), .rd(rd_a), .err(err_a));

   dmem_bytelane #(.DEPTH(DEPTH), .READ_LAT(LB), .CLEAR_ON_RESET(1)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .a(a), .wd(wd),
      .ready(rdy_b), .rsp_valid(vld_b), .rd(rd_b), .err(err_b));

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] rd;
      logic        err;
   } rsp_t;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   rel_cnt = 0;
   rsp_t qa[$];
   rsp_t qb[$];
   logic [7:0] mem_m [4*DEPTH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   // Reference: memory is a flat byte array; addresses wrap modulo 4*DEPTH bytes.
   task automatic model(input logic w, input logic [2:0] f, input logic [31:0] ad,
                        input logic [31:0] d, output logic [31:0] r, output logic e);
      int   base, lane, b;
      logic legal, mis;
      logic [15:0] h;
      base  = int'((ad / 4) % DEPTH) * 4;
      lane  = int'(ad % 4);
      b     = base + lane;
      legal = (f == 0 || f == 1 || f == 2) || (!w && (f == 4 || f == 5));
      mis   = ((f == 1 || f == 5) && (lane % 2 != 0)) || (f == 2 && lane != 0);
      e     = !legal || mis;
      r     = 32'b0;
      if (!e) begin
         if (w) begin
            if (f == 0) mem_m[b] = d[7:0];
            else if (f == 1) begin
               mem_m[b] = d[7:0]; mem_m[b+1] = d[15:8];
            end else
               for (int i = 0; i < 4; i++) mem_m[base+i] = d[8*i +: 8];
         end else begin
            h = {mem_m[b+1], mem_m[b]};
            case (f)
               3'd0: r = 32'($signed(mem_m[b]));
               3'd4: r = 32'(mem_m[b]);
               3'd1: r = 32'($signed(h));
               3'd5: r = 32'(h);
               default: r = {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
            endcase
         end
      end
   endtask

   task automatic check_outs();
      chk("ready_a", 32'(rdy_a), 32'(rst_n && rel_cnt >= DEPTH));
      chk("ready_b", 32'(rdy_b), 32'(rst_n && rel_cnt >= DEPTH));
      if (qa.size() > 0 && qa[0].due == cyc) begin
         chk("vld_a", 32'(vld_a), 32'd1);
         chk("rd_a", rd_a, qa[0].rd);
         chk("err_a", 32'(err_a), 32'(qa[0].err));
         void'(qa.pop_front());
      end else begin
         chk("idle_vld_a", 32'(vld_a), 32'd0);
         chk("idle_rd_a", rd_a, 32'd0);
         chk("idle_err_a", 32'(err_a), 32'd0);
      end
      if (qb.size() > 0 && qb[0].due == cyc) begin
         chk("vld_b", 32'(vld_b), 32'd1);
         chk("rd_b", rd_b, qb[0].rd);
         chk("err_b", 32'(err_b), 32'(qb[0].err));
         void'(qb.pop_front());
      end else begin
         chk("idle_vld_b", 32'(vld_b), 32'd0);
         chk("idle_rd_b", rd_b, 32'd0);
         chk("idle_err_b", 32'(err_b), 32'd0);
      end
   endtask

   // Called just after a falling edge; returns just after the next falling edge.
   task automatic step(input logic r, input logic w, input logic [2:0] f,
                       input logic [31:0] ad, input logic [31:0] d);
      logic        acc;
      logic [31:0] er;
      logic        ee;
      req = r; we = w; funct3 = f; a = ad; wd = d;
      acc = r && rst_n && (rel_cnt >= DEPTH);
      @(posedge clk);
      cyc++;
      if (rst_n) rel_cnt++;
      if (acc) begin
         model(w, f, ad, d, er, ee);
         qa.push_back('{cyc + LA - 1, er, ee});
         qb.push_back('{cyc + LB - 1, er, ee});
      end
      @(negedge clk);
      #1;
      req = 1'b0;
      check_outs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_ready", 32'(rdy_a | rdy_b), 32'd0);
      chk("rst_vld", 32'(vld_a | vld_b), 32'd0);
      chk("rst_rd", rd_a | rd_b, 32'd0);
      chk("rst_err", 32'(err_a | err_b), 32'd0);
      qa.delete();
      qb.delete();
      rel_cnt = 0;
   endtask

   task automatic release_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 4*DEPTH; i++) mem_m[i] = 8'h00;
   endtask

   task automatic ld_expect(input string tag, input logic [2:0] f, input logic [31:0] ad,
                            input logic [31:0] exp);
      step(1'b1, 1'b0, f, ad, 32'd0);
      chk(tag, rd_a, exp);
   endtask

   task automatic err_expect(input string tag, input logic w, input logic [2:0] f,
                             input logic [31:0] ad);
      step(1'b1, w, f, ad, 32'hFFFF_FFFF);
      chk(tag, {rd_a[30:0], err_a}, 32'd1);
   endtask

   initial begin
      logic [2:0] f;
      logic [2:0] legal_f [5];
      legal_f = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

      @(negedge clk);
      assert_reset();
      repeat (2) @(negedge clk);
      release_reset();
      // Requests during the clear must be ignored.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 3'd2, 32'h3C, 32'h1234_5678);
      ld_expect("lw_3c_cleared", 3'd2, 32'h3C, 32'h0000_0000);

      step(1'b1, 1'b1, 3'd2, 32'h4, 32'hAA55_AA55);
      ld_expect("lw_4", 3'd2, 32'h4, 32'hAA55_AA55);
      ld_expect("lb_5", 3'd0, 32'h5, 32'hFFFF_FFAA);
      ld_expect("lbu_5", 3'd4, 32'h5, 32'h0000_00AA);
      ld_expect("lh_6", 3'd1, 32'h6, 32'hFFFF_AA55);

      step(1'b1, 1'b1, 3'd2, 32'h8, 32'h1234_5678);
      step(1'b1, 1'b1, 3'd0, 32'h9, 32'h0000_00FF);
      step(1'b1, 1'b1, 3'd1, 32'hA, 32'h0000_BEEF);
      ld_expect("lw_8_merged", 3'd2, 32'h8, 32'hBEEF_FF78);

      err_expect("sw_misal", 1'b1, 3'd2, 32'h6);
      err_expect("lh_misal", 1'b0, 3'd1, 32'h3);
      err_expect("f3_011", 1'b0, 3'd3, 32'h4);
      err_expect("sbu_store", 1'b1, 3'd4, 32'h4);
      ld_expect("lw_4_intact", 3'd2, 32'h4, 32'hAA55_AA55);

      step(1'b1, 1'b1, 3'd2, 32'h40, 32'hDEAD_BEEF);
      ld_expect("lw_0_wrap", 3'd2, 32'h0, 32'hDEAD_BEEF);
      step(1'b1, 1'b0, 3'd2, 32'h4, 32'd0);
      step(1'b1, 1'b0, 3'd2, 32'h8, 32'd0);
      step(1'b1, 1'b0, 3'd4, 32'h9, 32'd0);
      idle(LB);

      // Reset in the middle of a clear, then a full clear from index 0.
      assert_reset();
      idle(2);
      release_reset();
      idle(5);
      assert_reset();
      idle(2);
      release_reset();
      idle(DEPTH);
      ld_expect("lw_0_after_reclear", 3'd2, 32'h0, 32'h0000_0000);

      // Reset with two long-latency loads still in flight.
      step(1'b1, 1'b1, 3'd2, 32'h10, 32'hCAFE_F00D);
      step(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
      step(1'b1, 1'b0, 3'd1, 32'h12, 32'd0);
      assert_reset();
      idle(LB + 1);
      release_reset();
      idle(DEPTH);

      for (int i = 0; i < 400; i++) begin
         f = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 7)) : legal_f[$urandom_range(0, 4)];
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), f,
              32'($urandom_range(0, 127)), $urandom);
      end
      idle(LB + 1);
      chk("queue_a_drained", 32'(qa.size()), 32'd0);
      chk("queue_b_drained", 32'(qb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
